// File: rtl/poly_pkg.sv
// Shared definitions for the polynomial command dispatcher: opcodes,
// status error codes, degree-table constants and controller states.
package poly_pkg;

    localparam logic [7:0] OP_STO = 8'd0;
    localparam logic [7:0] OP_EVP = 8'd1;
    localparam logic [7:0] OP_EVB = 8'd2;
    localparam logic [7:0] OP_RST = 8'd3;

    typedef enum logic [1:0] {
        ERR_OK    = 2'd0,
        ERR_INSTR = 2'd1,
        ERR_DEG   = 2'd2,
        ERR_EMPTY = 2'd3
    } err_e;

    localparam int         NUM_SLOTS = 8;
    localparam logic [3:0] N_EMPTY   = 4'd15;
    localparam logic [4:0] MAX_DEG   = 5'd10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_REPORT = 3'd4
    } state_e;

    // Extract the 4-bit degree of one slot from the flat table bus.
    function automatic logic [3:0] slot_deg(input logic [31:0] tbl, input logic [2:0] slot);
        return tbl[{slot, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/slot_table.sv
// Degree table: eight 4-bit entries with one write port, a clear-all
// control and a flat read bus (slot k at bits [4k+3:4k]).
module slot_table
    import poly_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en_i,
    input  logic [2:0]  wr_slot_i,
    input  logic [3:0]  wr_deg_i,
    input  logic        clr_i,
    output logic [31:0] n_table_o
);

    logic [3:0] deg_q [NUM_SLOTS];

    // Entry storage: empty on reset or clear, otherwise single-slot writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                deg_q[k] <= N_EMPTY;
            end
        end else if (clr_i) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                deg_q[k] <= N_EMPTY;
            end
        end else if (wr_en_i) begin
            deg_q[wr_slot_i] <= wr_deg_i;
        end else begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                deg_q[k] <= deg_q[k];
            end
        end
    end

    // Flatten the entries onto the read bus.
    always_comb begin
        n_table_o = 32'h0000_0000;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            n_table_o[4*k +: 4] = deg_q[k];
        end
    end

endmodule

// File: rtl/cmd_dispatch_ctrl.sv
// Command dispatcher: accepts one command word, validates it against the
// degree table, launches the matching execution unit, waits for its done
// pulse and reports a status word. All outputs are registered.
module cmd_dispatch_ctrl
    import poly_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [15:0] cmd_data,
    output logic        cmd_ready,
    output logic        start_sto,
    output logic        start_evp,
    output logic        start_evb,
    input  logic        done_sto,
    input  logic        done_evp,
    input  logic        done_evb,
    output logic [2:0]  op_slot,
    output logic [4:0]  op_arg,
    output logic [31:0] n_table,
    output logic        stat_valid,
    output logic [7:0]  stat_instr,
    output logic [1:0]  stat_error,
    input  logic        stat_ready
);

    state_e      state_q, state_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic [2:0]  start_q, start_d;        // {evb, evp, sto}
    logic [2:0]  op_slot_q, op_slot_d;
    logic [4:0]  op_arg_q, op_arg_d;
    logic        stat_valid_q, stat_valid_d;
    logic [7:0]  stat_instr_q, stat_instr_d;
    logic [1:0]  stat_error_q, stat_error_d;

    logic [7:0]  instr_s;
    logic [2:0]  arg1_s;
    logic [4:0]  arg2_s;
    logic [31:0] n_table_s;
    err_e        decode_err_s;
    logic        done_match_s;
    logic        tbl_we_s;
    logic        tbl_clr_s;

    assign instr_s = cmd_q[15:8];
    assign arg1_s  = cmd_q[7:5];
    assign arg2_s  = cmd_q[4:0];

    // Validate the captured command against the current table contents.
    // For EVB an empty slot is reported ahead of a zero batch size.
    always_comb begin
        decode_err_s = ERR_OK;
        case (instr_s)
            OP_STO: begin
                if (arg2_s > MAX_DEG) begin
                    decode_err_s = ERR_DEG;
                end else begin
                    decode_err_s = ERR_OK;
                end
            end
            OP_EVP: begin
                if (slot_deg(n_table_s, arg1_s) == N_EMPTY) begin
                    decode_err_s = ERR_EMPTY;
                end else begin
                    decode_err_s = ERR_OK;
                end
            end
            OP_EVB: begin
                if (slot_deg(n_table_s, arg1_s) == N_EMPTY) begin
                    decode_err_s = ERR_EMPTY;
                end else if (arg2_s == 5'd0) begin
                    decode_err_s = ERR_DEG;
                end else begin
                    decode_err_s = ERR_OK;
                end
            end
            OP_RST:  decode_err_s = ERR_OK;
            default: decode_err_s = ERR_INSTR;
        endcase
    end

    // Select the done pulse of the unit that the captured command targets.
    always_comb begin
        done_match_s = 1'b0;
        case (instr_s)
            OP_STO:  done_match_s = done_sto;
            OP_EVP:  done_match_s = done_evp;
            OP_EVB:  done_match_s = done_evb;
            default: done_match_s = 1'b0;
        endcase
    end

    // Next-state, table control and next values of the registered outputs.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        start_d      = 3'b000;
        op_slot_d    = op_slot_q;
        op_arg_d     = op_arg_q;
        stat_instr_d = stat_instr_q;
        stat_error_d = stat_error_q;
        tbl_we_s     = 1'b0;
        tbl_clr_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_d   = cmd_data;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (decode_err_s != ERR_OK) begin
                    state_d      = ST_REPORT;
                    stat_instr_d = instr_s;
                    stat_error_d = decode_err_s;
                end else if (instr_s == OP_RST) begin
                    state_d      = ST_REPORT;
                    tbl_clr_s    = 1'b1;
                    stat_instr_d = instr_s;
                    stat_error_d = ERR_OK;
                end else begin
                    state_d   = ST_ISSUE;
                    op_slot_d = arg1_s;
                    op_arg_d  = arg2_s;
                    case (instr_s)
                        OP_STO:  start_d = 3'b001;
                        OP_EVP:  start_d = 3'b010;
                        OP_EVB:  start_d = 3'b100;
                        default: start_d = 3'b000;
                    endcase
                end
            end
            ST_ISSUE, ST_WAIT: begin
                // A done arriving during ISSUE is honoured just like one in WAIT.
                if (done_match_s) begin
                    state_d      = ST_REPORT;
                    stat_instr_d = instr_s;
                    stat_error_d = ERR_OK;
                    if (instr_s == OP_STO) begin
                        tbl_we_s = 1'b1;
                    end else begin
                        tbl_we_s = 1'b0;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_REPORT: begin
                if (stat_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REPORT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cmd_ready_d  = (state_d == ST_IDLE);
        stat_valid_d = (state_d == ST_REPORT);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cmd_q        <= 16'h0000;
            cmd_ready_q  <= 1'b0;
            start_q      <= 3'b000;
            op_slot_q    <= 3'd0;
            op_arg_q     <= 5'd0;
            stat_valid_q <= 1'b0;
            stat_instr_q <= 8'd0;
            stat_error_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            cmd_ready_q  <= cmd_ready_d;
            start_q      <= start_d;
            op_slot_q    <= op_slot_d;
            op_arg_q     <= op_arg_d;
            stat_valid_q <= stat_valid_d;
            stat_instr_q <= stat_instr_d;
            stat_error_q <= stat_error_d;
        end
    end

    slot_table u_slot_table (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (tbl_we_s),
        .wr_slot_i (arg1_s),
        .wr_deg_i  (arg2_s[3:0]),
        .clr_i     (tbl_clr_s),
        .n_table_o (n_table_s)
    );

    assign cmd_ready  = cmd_ready_q;
    assign start_sto  = start_q[0];
    assign start_evp  = start_q[1];
    assign start_evb  = start_q[2];
    assign op_slot    = op_slot_q;
    assign op_arg     = op_arg_q;
    assign n_table    = n_table_s;
    assign stat_valid = stat_valid_q;
    assign stat_instr = stat_instr_q;
    assign stat_error = stat_error_q;

endmodule

// File: tb/tb_cmd_dispatch_ctrl.sv
// Bench for cmd_dispatch_ctrl: directed scenarios followed by random
// commands, checked against a slot-array model of the degree table.
module tb_cmd_dispatch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [15:0] cmd_data;
    logic        cmd_ready;
    logic        start_sto, start_evp, start_evb;
    logic        done_sto, done_evp, done_evb;
    logic [2:0]  op_slot;
    logic [4:0]  op_arg;
    logic [31:0] n_table;
    logic        stat_valid;
    logic [7:0]  stat_instr;
    logic [1:0]  stat_error;
    logic        stat_ready;

    int n_checks = 0;
    int n_errors = 0;
    int mdeg [8];

    always #5 clk = ~clk;

    cmd_dispatch_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .cmd_ready  (cmd_ready),
        .start_sto  (start_sto),
        .start_evp  (start_evp),
        .start_evb  (start_evb),
        .done_sto   (done_sto),
        .done_evp   (done_evp),
        .done_evb   (done_evb),
        .op_slot    (op_slot),
        .op_arg     (op_arg),
        .n_table    (n_table),
        .stat_valid (stat_valid),
        .stat_instr (stat_instr),
        .stat_error (stat_error),
        .stat_ready (stat_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_table();
        logic [31:0] t;
        t = 32'h0;
        for (int k = 0; k < 8; k++) t[4*k +: 4] = mdeg[k][3:0];
        return t;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 8; k++) mdeg[k] = 15;
    endfunction

    // Status error code the specification prescribes for a command.
    function automatic int model_err(input logic [15:0] c);
        int instr, slot, a2;
        instr = c[15:8];
        slot  = c[7:5];
        a2    = c[4:0];
        if (instr == 0) return (a2 > 10) ? 2 : 0;
        if (instr == 1) return (mdeg[slot] == 15) ? 3 : 0;
        if (instr == 2) begin
            if (mdeg[slot] == 15) return 3;
            if (a2 == 0) return 2;
            return 0;
        end
        if (instr == 3) return 0;
        return 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_eq("ready_timeout", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic drive_dones(input logic [2:0] d);
        done_sto = d[0];
        done_evp = d[1];
        done_evb = d[2];
    endtask

    // One full command: accept, decode, optional unit run, report, release.
    task automatic run_cmd(input logic [15:0] c, input int lat, input int hold, input bit stray);
        int instr, slot, a2, err;
        logic [2:0] unit;
        instr = c[15:8];
        slot  = c[7:5];
        a2    = c[4:0];
        err   = model_err(c);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_data  = c;
        tick();
        // Junk offered while busy must not be captured.
        cmd_valid = stray;
        cmd_data  = 16'($urandom);
        check_eq("busy_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        if (err != 0 || instr == 3) begin
            if (instr == 3) model_clear();
            check_eq("no_start", {29'd0, start_evb, start_evp, start_sto}, 32'd0);
        end else begin
            unit = (instr == 0) ? 3'b001 : (instr == 1) ? 3'b010 : 3'b100;
            check_eq("start_pulse", {29'd0, start_evb, start_evp, start_sto}, {29'd0, unit});
            check_eq("op_slot", {29'd0, op_slot}, slot);
            check_eq("op_arg", {27'd0, op_arg}, a2);
            for (int i = 0; i < lat; i++) begin
                if (stray) drive_dones(~unit);
                tick();
                drive_dones(3'b000);
                check_eq("wait_start", {29'd0, start_evb, start_evp, start_sto}, 32'd0);
                check_eq("wait_stat", {31'd0, stat_valid}, 32'd0);
                check_eq("wait_slot", {24'd0, op_slot, op_arg}, {24'd0, slot[2:0], a2[4:0]});
            end
            cmd_valid = 1'b0;
            drive_dones(unit);
            tick();
            drive_dones(3'b000);
            if (instr == 0) mdeg[slot] = a2;
        end
        cmd_valid = 1'b0;
        check_eq("stat_valid", {31'd0, stat_valid}, 32'd1);
        check_eq("stat_instr", {24'd0, stat_instr}, instr & 255);
        check_eq("stat_error", {30'd0, stat_error}, err);
        check_eq("n_table", n_table, model_table());
        for (int i = 0; i < hold; i++) begin
            tick();
            check_eq("hold_status", {21'd0, stat_valid, stat_instr, stat_error},
                     {21'd0, 1'b1, 8'(instr), 2'(err)});
            check_eq("hold_ready", {31'd0, cmd_ready}, 32'd0);
        end
        stat_ready = 1'b1;
        tick();
        stat_ready = 1'b0;
        check_eq("report_done", {31'd0, stat_valid}, 32'd0);
        check_eq("back_idle", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_table", n_table, 32'hFFFF_FFFF);
        check_eq("rst_ready", {31'd0, cmd_ready}, 32'd0);
        check_eq("rst_start", {29'd0, start_evb, start_evp, start_sto}, 32'd0);
        check_eq("rst_stat", {21'd0, stat_valid, stat_instr, stat_error}, 32'd0);
        check_eq("rst_op", {24'd0, op_slot, op_arg}, 32'd0);
    endtask

    initial begin
        logic [15:0] c;
        int r;
        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_data   = 16'h0000;
        stat_ready = 1'b0;
        drive_dones(3'b000);
        model_clear();
        repeat (3) tick();
        check_reset_outputs();
        reset = 1'b1;

        // Store, over-degree store, empty-slot evaluate, then a valid one.
        run_cmd(16'h0043, 2, 0, 1'b0);
        check_eq("nibble2", {28'd0, n_table[11:8]}, 32'd3);
        run_cmd(16'h000C, 0, 1, 1'b0);
        run_cmd(16'h01A0, 0, 0, 1'b0);
        run_cmd(16'h00A4, 1, 0, 1'b1);
        run_cmd(16'h01A0, 2, 2, 1'b1);
        // Bad opcode, then table reset with loaded slots.
        run_cmd(16'h0700, 0, 0, 1'b0);
        run_cmd(16'h0300, 0, 1, 1'b0);
        check_eq("rst_cmd_table", n_table, 32'hFFFF_FFFF);
        // Batch evaluate with stray dones and a slow consumer; same-cycle done.
        run_cmd(16'h0025, 0, 0, 1'b0);
        run_cmd(16'h0223, 3, 5, 1'b1);
        run_cmd(16'h0220, 0, 0, 1'b0);
        run_cmd(16'h0120, 0, 0, 1'b0);

        // Reset while waiting on the batch unit, then a late done.
        wait_ready();
        cmd_valid = 1'b1;
        cmd_data  = 16'h0223;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check_eq("mid_wait_stat", {31'd0, stat_valid}, 32'd0);
        reset = 1'b0;
        #1;
        model_clear();
        check_reset_outputs();
        tick();
        reset = 1'b1;
        done_evb = 1'b1;
        tick();
        done_evb = 1'b0;
        repeat (2) begin
            tick();
            check_eq("late_done_stat", {31'd0, stat_valid}, 32'd0);
            check_eq("late_done_start", {29'd0, start_evb, start_evp, start_sto}, 32'd0);
        end
        check_eq("late_done_table", n_table, 32'hFFFF_FFFF);

        // Random commands.
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            c[7:5] = 3'($urandom_range(0, 7));
            c[4:0] = 5'($urandom_range(0, 14));
            if (r <= 2 || r == 9)      c[15:8] = 8'd0;
            else if (r <= 4)           c[15:8] = 8'd1;
            else if (r <= 6)           c[15:8] = 8'd2;
            else if (r == 7)           c[15:8] = ($urandom_range(0, 3) == 0) ? 8'd3 : 8'd0;
            else                       c[15:8] = 8'($urandom_range(4, 255));
            run_cmd(c, $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cmd_dispatch_ctrl.md
CMD_DISPATCH_CTRL -- requirements
Module: cmd_dispatch_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  system clock, rising edge.
REQ-002 SHALL have port: reset  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: cmd_valid  input  1  command word present; cmd_data  input  16  command, [15:8] instr, [7:5] arg1 (slot), [4:0] arg2; cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
REQ-004 SHALL have ports: start_sto, start_evp, start_evb  output  1 each  one-cycle start pulses to store, evaluate-point and evaluate-batch units.
REQ-005 SHALL have ports: done_sto, done_evp, done_evb  input  1 each  one-cycle completion pulses from those units.
REQ-006 SHALL have ports: op_slot  output  3  slot for the active unit; op_arg  output  5  arg2 for the active unit.
REQ-007 SHALL have port: n_table  output  32  degree table, slot k at bits [4k+3:4k], 15 = empty.
REQ-008 SHALL have ports: stat_valid  output  1  status present; stat_instr  output  8  instr reported; stat_error  output  2  0 ok, 1 bad instr, 2 bad degree, 3 empty slot; stat_ready  input  1  status consumed.

Function
REQ-009 SHALL implement states IDLE, DECODE, ISSUE, WAIT, REPORT.
REQ-010 SHALL drive cmd_ready=1 only in IDLE; on accept, SHALL capture cmd_data and go to DECODE.
REQ-011 In DECODE, SHALL check the captured command in one cycle.
- instr 0 (STO): arg2 > 10 -> error 2.
- instr 1 (EVP) or instr 2 (EVB): N[arg1] == 15 -> error 3.
- instr 2 (EVB): arg2 == 0 -> error 2.
- instr 3 (RST): error 0.
- any other instr: error 1.
REQ-012 On error, SHALL go DECODE->REPORT with no start pulse and no table change.
REQ-013 For RST, SHALL set all eight N entries to 15 on the DECODE->REPORT edge.
REQ-014 For valid STO/EVP/EVB, SHALL go DECODE->ISSUE and pulse exactly one matching start_* for one cycle in ISSUE, then go to WAIT.
REQ-015 op_slot/op_arg SHALL hold the captured arg1/arg2 from ISSUE through WAIT.
REQ-016 In WAIT, SHALL ignore every done_* except the one matching the issued unit; on that done, SHALL go to REPORT.
REQ-017 For STO, SHALL write N[arg1] <= arg2[3:0] on the cycle the matching done_sto is sampled.
REQ-018 A done_* pulse in the ISSUE cycle itself SHALL be accepted (same-cycle done).
REQ-019 In REPORT, SHALL hold stat_valid=1 with stat_instr/stat_error stable until stat_ready=1, then go to IDLE.
REQ-020 A stat_ready=1 on REPORT entry SHALL complete REPORT in one cycle.
REQ-021 Minimum command-to-status latency SHALL be: error/RST 2 cycles after accept; unit commands 3 cycles plus unit latency.
REQ-022 cmd_valid while not in IDLE SHALL be ignored (no capture).
REQ-023 stat_error for successful commands SHALL be 0.

Reset
REQ-024 While reset=0, SHALL hold: state IDLE, all N entries 15, cmd_ready 0, all start_* 0, stat_valid 0, stat_instr 0, stat_error 0, op_slot 0, op_arg 0.
REQ-025 Reset mid-operation SHALL abandon the command without reporting it; late done_* pulses in IDLE SHALL be ignored.

Structure
REQ-026 Opcodes (STO=0, EVP=1, EVB=2, RST=3), error codes, N_EMPTY=15, MAX_DEG=10 and NUM_SLOTS=8 SHALL live in the shared package poly_pkg.
REQ-027 The degree table SHALL be a sub-module slot_table: 8x4 registers with write port, clear-all and flat read bus.

Verification
REQ-028 Reset -> n_table=0xFFFFFFFF; accept 0x0043 (STO slot2 deg3) -> start_sto pulse with op_slot=2, op_arg=3; done_sto -> nibble2=3; status {0,0}.
REQ-029 Accept 0x000C (STO deg12) -> no start pulse, status {instr 0, error 2}, table unchanged.
REQ-030 Accept 0x01A0 (EVP slot5, empty) -> status {1,3}; after STO slot5, same command -> start_evp, then status {1,0}.
REQ-031 Accept 0x0700 -> status {7,1}; accept 0x0300 after loaded slots -> n_table=0xFFFFFFFF, status {3,0}.
REQ-032 EVB issued, stray done_sto in WAIT -> remains WAIT; done_evb -> REPORT; stat_ready held low 5 cycles -> status stable, cmd_ready=0 throughout.
REQ-033 Reset asserted in WAIT -> IDLE, no status, table reset to empty; a later done_evb pulse -> no effect.
